// File: rtl/dmux_stream.sv
// Registered 1-to-N stream demultiplexer with a one-word holding register per
// output channel, so a stalled consumer never blocks traffic to the others.
module dmux_stream #(
    parameter int WIDTH     = 8,
    parameter int N_OUT     = 4,
    parameter int SEL_W     = 2,
    parameter int ZERO_IDLE = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       entrada,
    input  logic [SEL_W-1:0]       sel,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [N_OUT*WIDTH-1:0] out_data,
    output logic [N_OUT-1:0]       out_valid,
    input  logic [N_OUT-1:0]       out_ready,
    output logic                   sel_err,
    output logic [7:0]             drop_cnt
);

    // Handshake: a word moves when valid & ready are both high at a rising
    // edge; in_ready never looks at in_valid, and a held word stays stable.
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} ch_state_t;

    localparam logic [SEL_W:0] N_OUT_L = (SEL_W+1)'(N_OUT);

    ch_state_t        state_q [N_OUT];
    ch_state_t        state_d [N_OUT];
    logic [WIDTH-1:0] data_q  [N_OUT];
    logic [WIDTH-1:0] data_d  [N_OUT];
    logic [N_OUT-1:0] hit;
    logic [N_OUT-1:0] wr;
    logic             sel_ok;
    logic             drop;
    logic             sel_err_d;
    logic [7:0]       drop_cnt_d;

    always_comb begin
        sel_ok   = ({1'b0, sel} < N_OUT_L);
        in_ready = 1'b1;
        hit      = '0;
        for (int k = 0; k < N_OUT; k++) begin
            hit[k] = (sel == SEL_W'(k));
            if (hit[k]) begin
                in_ready = (state_q[k] == EMPTY) | out_ready[k];
            end
        end
    end

    // Channel FSMs: a write wins over a drain, which gives drain+refill with no bubble.
    always_comb begin
        wr         = '0;
        drop       = in_valid & ~sel_ok;
        sel_err_d  = drop;
        drop_cnt_d = drop_cnt;
        if (drop && drop_cnt != 8'hFF) begin
            drop_cnt_d = drop_cnt + 8'd1;
        end
        for (int k = 0; k < N_OUT; k++) begin
            state_d[k] = state_q[k];
            data_d[k]  = data_q[k];
            wr[k]      = in_valid & in_ready & hit[k];
            if (wr[k]) begin
                state_d[k] = FULL;
                data_d[k]  = entrada;
            end else if (state_q[k] == FULL && out_ready[k]) begin
                state_d[k] = EMPTY;
                data_d[k]  = (ZERO_IDLE != 0) ? '0 : data_q[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N_OUT; k++) begin
                state_q[k] <= EMPTY;
                data_q[k]  <= '0;
            end
            sel_err  <= 1'b0;
            drop_cnt <= 8'd0;
        end else begin
            for (int k = 0; k < N_OUT; k++) begin
                state_q[k] <= state_d[k];
                data_q[k]  <= data_d[k];
            end
            sel_err  <= sel_err_d;
            drop_cnt <= drop_cnt_d;
        end
    end

    // out_valid is the per-channel FSM state bit, observable directly.
    always_comb begin
        for (int k = 0; k < N_OUT; k++) begin
            out_valid[k]               = (state_q[k] == FULL);
            out_data[k*WIDTH +: WIDTH] = data_q[k];
        end
    end

endmodule

// File: tb/tb_dmux_stream.sv
// Bench for dmux_stream: a 4-channel instance with a per-channel scoreboard
// and a 3-channel instance for out-of-range select handling.
module tb_dmux_stream;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  entrada = '0;
    logic [1:0]  sel = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] out_data;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready = '0;
    logic        sel_err;
    logic [7:0]  drop_cnt;

    logic [1:0]  sel3 = '0;
    logic        in_valid3 = 1'b0;
    logic        in_ready3;
    logic [23:0] out_data3;
    logic [2:0]  out_valid3;
    logic [2:0]  out_ready3 = 3'b111;
    logic        sel_err3;
    logic [7:0]  drop_cnt3;

    int          n_checks = 0;
    int          n_errors = 0;
    logic        armed = 1'b0;
    logic [7:0]  exp_q [4][$];
    logic [7:0]  exp_v;
    logic        err_pend3 = 1'b0;
    int          exp_drop3 = 0;

    always #5 clk = ~clk;

    dmux_stream #(.WIDTH(8), .N_OUT(4), .SEL_W(2), .ZERO_IDLE(1)) u_dut4 (
        .clk(clk), .rst(rst), .entrada(entrada), .sel(sel), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .sel_err(sel_err), .drop_cnt(drop_cnt)
    );

    dmux_stream #(.WIDTH(8), .N_OUT(3), .SEL_W(2), .ZERO_IDLE(1)) u_dut3 (
        .clk(clk), .rst(rst), .entrada(entrada), .sel(sel3), .in_valid(in_valid3),
        .in_ready(in_ready3), .out_data(out_data3), .out_valid(out_valid3),
        .out_ready(out_ready3), .sel_err(sel_err3), .drop_cnt(drop_cnt3)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic [7:0] d,
                         input logic [3:0] r);
        @(posedge clk);
        #1;
        in_valid  = v;
        sel       = s;
        entrada   = d;
        out_ready = r;
        @(negedge clk);
    endtask

    // Scoreboard for the 4-channel instance: pops on output transfers, pushes on input transfers.
    always @(negedge clk) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) exp_q[k].delete();
        end else if (armed) begin
            for (int k = 0; k < 4; k++) begin
                if (out_valid[k]) begin
                    if (exp_q[k].size() == 0) begin
                        check($sformatf("ch%0d_unexpected", k), 32'(out_data[k*8 +: 8]), 32'hFFFF_FFFF);
                    end else begin
                        check($sformatf("ch%0d_data", k), 32'(out_data[k*8 +: 8]), 32'(exp_q[k][0]));
                        if (out_ready[k]) exp_v = exp_q[k].pop_front();
                    end
                end else begin
                    check($sformatf("ch%0d_idle_zero", k), 32'(out_data[k*8 +: 8]), 32'h0);
                end
            end
            if (in_valid && in_ready) exp_q[sel].push_back(entrada);
        end
    end

    // Drop model for the 3-channel instance.
    always @(negedge clk) begin
        if (rst) begin
            err_pend3 = 1'b0;
            exp_drop3 = 0;
        end else if (armed) begin
            check("sel_err3", 32'(sel_err3), 32'(err_pend3));
            check("drop_cnt3", 32'(drop_cnt3), 32'(exp_drop3));
            err_pend3 = in_valid3 && (sel3 >= 2'd3);
            if (err_pend3 && exp_drop3 != 255) exp_drop3++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Reset held two cycles with traffic offered to both instances
        in_valid  = 1'b1;
        sel       = 2'd0;
        entrada   = 8'hFF;
        out_ready = 4'hF;
        in_valid3 = 1'b1;
        sel3      = 2'd3;
        repeat (2) @(posedge clk);
        #1;
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_valid3 = 1'b0;
        armed     = 1'b1;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_data", out_data, 32'h0);
        check("rst_drop_cnt", 32'(drop_cnt), 32'h0);
        check("rst_sel_err", 32'(sel_err), 32'h0);
        check("rst_out_valid3", 32'(out_valid3), 32'h0);

        // Routing at full rate
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 2'(k), 8'(8'hA0 + k), 4'hF);
            check("rt_in_ready", 32'(in_ready), 32'h1);
            check("rt_valid", 32'(out_valid), (k == 0) ? 32'h0 : 32'(1 << (k - 1)));
        end
        drive(1'b0, 2'd0, 8'h00, 4'hF);
        check("rt_valid_last", 32'(out_valid), 32'h8);
        check("rt_data_last", 32'(out_data[31:24]), 32'hA3);
        drive(1'b0, 2'd0, 8'h00, 4'hF);
        check("rt_valid_idle", 32'(out_valid), 32'h0);

        // Stall isolation on channel 2
        drive(1'b1, 2'd2, 8'h55, 4'b1011);
        check("st_in_ready_first", 32'(in_ready), 32'h1);
        drive(1'b1, 2'd2, 8'h66, 4'b1011);
        check("st_in_ready_blocked", 32'(in_ready), 32'h0);
        drive(1'b1, 2'd1, 8'h77, 4'b1011);
        check("st_in_ready_other", 32'(in_ready), 32'h1);
        check("st_ch2_hold", 32'(out_data[23:16]), 32'h55);
        drive(1'b0, 2'd0, 8'h00, 4'b1011);
        check("st_valid", 32'(out_valid), 32'h6);
        check("st_ch1_data", 32'(out_data[15:8]), 32'h77);
        drive(1'b0, 2'd0, 8'h00, 4'hF);
        check("st_valid_release", 32'(out_valid), 32'h4);
        drive(1'b0, 2'd0, 8'h00, 4'hF);
        check("st_valid_drained", 32'(out_valid), 32'h0);

        // Drain and refill channel 0 in one cycle
        drive(1'b1, 2'd0, 8'h11, 4'b1110);
        drive(1'b0, 2'd0, 8'h00, 4'b1110);
        check("dr_valid_full", 32'(out_valid), 32'h1);
        drive(1'b1, 2'd0, 8'h22, 4'hF);
        check("dr_in_ready", 32'(in_ready), 32'h1);
        drive(1'b0, 2'd0, 8'h00, 4'hF);
        check("dr_valid_kept", 32'(out_valid), 32'h1);
        check("dr_data_new", 32'(out_data[7:0]), 32'h22);
        drive(1'b0, 2'd0, 8'h00, 4'hF);
        check("dr_valid_empty", 32'(out_valid), 32'h0);

        // Random traffic against the scoreboard
        for (int i = 0; i < 200; i++) begin
            drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)));
        end
        repeat (2) drive(1'b0, 2'd0, 8'h00, 4'hF);
        check("rnd_valid_empty", 32'(out_valid), 32'h0);

        // Reset while channel 1 is full and stalled
        drive(1'b1, 2'd1, 8'h5A, 4'b1101);
        drive(1'b0, 2'd1, 8'h00, 4'b1101);
        check("rs_valid_full", 32'(out_valid), 32'h2);
        check("rs_in_ready_stalled", 32'(in_ready), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rs_valid_cleared", 32'(out_valid), 32'h0);
        check("rs_in_ready", 32'(in_ready), 32'h1);

        // Highest legal channel of the 3-channel instance
        @(posedge clk);
        #1;
        in_valid3 = 1'b1;
        sel3      = 2'd2;
        entrada   = 8'h3C;
        @(negedge clk);
        check("n3_in_ready", 32'(in_ready3), 32'h1);
        @(posedge clk);
        #1;
        in_valid3 = 1'b0;
        @(negedge clk);
        check("n3_valid", 32'(out_valid3), 32'h4);
        check("n3_data", 32'(out_data3[23:16]), 32'h3C);

        // Out-of-range select for 300 cycles: saturating drop count
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            in_valid3 = 1'b1;
            sel3      = 2'd3;
            entrada   = 8'($urandom_range(0, 255));
            @(negedge clk);
            check("bs_in_ready", 32'(in_ready3), 32'h1);
            check("bs_no_valid", 32'(out_valid3), 32'h0);
        end
        @(posedge clk);
        #1;
        in_valid3 = 1'b0;
        repeat (2) @(negedge clk);
        check("bs_drop_sat", 32'(drop_cnt3), 32'd255);
        check("bs_sel_err_low", 32'(sel_err3), 32'h0);

        repeat (2) drive(1'b0, 2'd0, 8'h00, 4'hF);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("sb_left_ch%0d", k), 32'(exp_q[k].size()), 32'h0);
        end
        check("n4_drop_cnt", 32'(drop_cnt), 32'h0);
        check("n4_sel_err", 32'(sel_err), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
